// File: rtl/store_guard_ctrl_pkg.sv
// Shared definitions for the store guard.
//   riscv      : architectural address width (VLEN).
//   ariane_pkg : guard FSM state type, default buffer depth and
//                debug read-port widths.
// No ports; imported by store_guard_ctrl and guard_entry_buffer.

package riscv;
    localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
    // Guard controller states. Only IDLE accepts new requests.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ALERT = 2'd2,
        FLUSH = 2'd3
    } guard_state_e;

    localparam int unsigned GUARD_NR_ENTRIES = 6;
    localparam int unsigned GUARD_RD_IDX_W   = 20;
    localparam int unsigned GUARD_RD_DATA_W  = 32;
endpackage

// File: rtl/store_guard_ctrl_entry_buffer.sv
// guard_entry_buffer: circular store of protected addresses with match logic.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   wr_en_i, wr_addr_i write request; an address already present is dropped
//   clear_i            invalidate everything, rewind pointer and occupancy
//   find_addr_i        address looked up against valid entries
//   find_hit_o         combinational match result for find_addr_i
//   rd_index_i         debug read slot
//   rd_data_o          slot contents truncated to 32 bits, 0 if empty/out of range
//   occupancy_o        number of valid entries (saturates at NR_ENTRIES)

module guard_entry_buffer
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = GUARD_NR_ENTRIES,
    parameter int unsigned ADDR_W     = riscv::VLEN
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              wr_en_i,
    input  logic [ADDR_W-1:0]                 wr_addr_i,
    input  logic                              clear_i,
    input  logic [ADDR_W-1:0]                 find_addr_i,
    output logic                              find_hit_o,
    input  logic [GUARD_RD_IDX_W-1:0]         rd_index_i,
    output logic [GUARD_RD_DATA_W-1:0]        rd_data_o,
    output logic [$clog2(NR_ENTRIES+1)-1:0]   occupancy_o
);

    localparam int unsigned PTR_W = $clog2(NR_ENTRIES);
    localparam int unsigned CNT_W = $clog2(NR_ENTRIES + 1);

    logic [ADDR_W-1:0]     entry_addr [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] entry_valid;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic                  wr_dup;
    logic [PTR_W-1:0]      rd_slot;

    // Two independent full-width comparators: one for the lookup port and
    // one that suppresses duplicate writes.
    always_comb begin
        find_hit_o = 1'b0;
        wr_dup     = 1'b0;
        for (int i = 0; i < int'(NR_ENTRIES); i++) begin
            if (entry_valid[i] && (entry_addr[i] == find_addr_i)) find_hit_o = 1'b1;
            if (entry_valid[i] && (entry_addr[i] == wr_addr_i))   wr_dup     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_valid <= '0;
            wr_ptr      <= '0;
            occupancy   <= '0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) entry_addr[i] <= '0;
        end else if (clear_i) begin
            entry_valid <= '0;
            wr_ptr      <= '0;
            occupancy   <= '0;
        end else if (wr_en_i && !wr_dup) begin
            // When full, wr_ptr already points at the oldest entry.
            entry_addr[wr_ptr]  <= wr_addr_i;
            entry_valid[wr_ptr] <= 1'b1;
            wr_ptr    <= (wr_ptr == PTR_W'(NR_ENTRIES - 1)) ? '0 : wr_ptr + 1'b1;
            if (occupancy != CNT_W'(NR_ENTRIES)) occupancy <= occupancy + 1'b1;
        end
    end

    assign occupancy_o = occupancy;
    assign rd_slot     = rd_index_i[PTR_W-1:0];

    always_comb begin
        rd_data_o = '0;
        if (rd_index_i < GUARD_RD_IDX_W'(NR_ENTRIES)) begin
            if (entry_valid[rd_slot]) rd_data_o = GUARD_RD_DATA_W'(entry_addr[rd_slot]);
        end
    end

endmodule

// File: rtl/store_guard_ctrl.sv
// store_guard_ctrl: protects recorded frame-pointer store targets. A check
// request whose address matches a recorded entry raises crash_o (unless the
// core is in debug mode) until acknowledged, after which the buffer is flushed.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   debug_mode_i                report hits without raising crash_o
//   rec_valid_i/rec_ready_o     record handshake, rec_addr_i address to protect
//   chk_valid_i/chk_ready_o     check handshake, chk_addr_i address to test
//   chk_done_o/chk_hit_o        one-cycle result pulse and hit flag
//   flush_i                     clear all entries (honoured in IDLE only)
//   crash_o/crash_ack_i         violation alarm and its acknowledge
//   fault_addr_o                address of the last violation
//   rd_index_i/rd_data_o        debug read of one buffer slot
//   occupancy_o                 number of valid entries
//   state_o                     current FSM state (debug visibility)
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both high; ready never depends on anything but the FSM state and the other
// requests' valid inputs, and a requester holds valid/addr until transfer.

module store_guard_ctrl
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = GUARD_NR_ENTRIES,
    parameter int unsigned ADDR_W     = riscv::VLEN
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              debug_mode_i,
    input  logic                              rec_valid_i,
    output logic                              rec_ready_o,
    input  logic [ADDR_W-1:0]                 rec_addr_i,
    input  logic                              chk_valid_i,
    output logic                              chk_ready_o,
    input  logic [ADDR_W-1:0]                 chk_addr_i,
    output logic                              chk_done_o,
    output logic                              chk_hit_o,
    input  logic                              flush_i,
    output logic                              crash_o,
    input  logic                              crash_ack_i,
    output logic [ADDR_W-1:0]                 fault_addr_o,
    input  logic [GUARD_RD_IDX_W-1:0]         rd_index_i,
    output logic [GUARD_RD_DATA_W-1:0]        rd_data_o,
    output logic [$clog2(NR_ENTRIES+1)-1:0]   occupancy_o,
    output guard_state_e                      state_o
);

    guard_state_e      state_q, state_d;
    logic [ADDR_W-1:0] chk_addr_q;
    logic [ADDR_W-1:0] fault_addr_q;
    logic              chk_load;
    logic              fault_load;
    logic              buf_wr;
    logic              buf_clear;
    logic              find_hit;

    guard_entry_buffer #(
        .NR_ENTRIES (NR_ENTRIES),
        .ADDR_W     (ADDR_W)
    ) u_entries (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_en_i     (buf_wr),
        .wr_addr_i   (rec_addr_i),
        .clear_i     (buf_clear),
        .find_addr_i (chk_addr_q),
        .find_hit_o  (find_hit),
        .rd_index_i  (rd_index_i),
        .rd_data_o   (rd_data_o),
        .occupancy_o (occupancy_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            chk_addr_q   <= '0;
            fault_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (chk_load)   chk_addr_q   <= chk_addr_i;
            if (fault_load) fault_addr_q <= chk_addr_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        rec_ready_o = 1'b0;
        chk_ready_o = 1'b0;
        chk_load    = 1'b0;
        fault_load  = 1'b0;
        buf_wr      = 1'b0;
        buf_clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // flush beats check beats record.
                chk_ready_o = !flush_i;
                rec_ready_o = !flush_i && !chk_valid_i;
                if (flush_i) begin
                    state_d = FLUSH;
                end else if (chk_valid_i) begin
                    state_d  = CHECK;
                    chk_load = 1'b1;
                end else if (rec_valid_i) begin
                    buf_wr = 1'b1;
                end
            end
            CHECK: begin
                // Entries cannot change during the accept cycle, so the
                // lookup against chk_addr_q reflects the buffer at accept time.
                if (find_hit && !debug_mode_i) begin
                    state_d    = ALERT;
                    fault_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ALERT: begin
                if (crash_ack_i) state_d = FLUSH;
            end
            FLUSH: begin
                buf_clear = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign chk_done_o   = (state_q == CHECK);
    assign chk_hit_o    = (state_q == CHECK) && find_hit;
    assign crash_o      = (state_q == ALERT);
    assign fault_addr_o = fault_addr_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_store_guard_ctrl.sv
// Bench for store_guard_ctrl: directed sequences with literal expectations
// plus an address-history model compared on every falling edge.

module tb_store_guard_ctrl;
    import ariane_pkg::*;

    localparam int NR    = 6;
    localparam int AW    = 64;
    localparam int OCC_W = $clog2(NR + 1);

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              debug_mode_i;
    logic              rec_valid_i;
    logic              rec_ready_o;
    logic [AW-1:0]     rec_addr_i;
    logic              chk_valid_i;
    logic              chk_ready_o;
    logic [AW-1:0]     chk_addr_i;
    logic              chk_done_o;
    logic              chk_hit_o;
    logic              flush_i;
    logic              crash_o;
    logic              crash_ack_i;
    logic [AW-1:0]     fault_addr_o;
    logic [19:0]       rd_index_i;
    logic [31:0]       rd_data_o;
    logic [OCC_W-1:0]  occupancy_o;
    guard_state_e      state_o;

    store_guard_ctrl #(.NR_ENTRIES(NR), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .debug_mode_i(debug_mode_i),
        .rec_valid_i(rec_valid_i), .rec_ready_o(rec_ready_o), .rec_addr_i(rec_addr_i),
        .chk_valid_i(chk_valid_i), .chk_ready_o(chk_ready_o), .chk_addr_i(chk_addr_i),
        .chk_done_o(chk_done_o), .chk_hit_o(chk_hit_o), .flush_i(flush_i),
        .crash_o(crash_o), .crash_ack_i(crash_ack_i), .fault_addr_o(fault_addr_o),
        .rd_index_i(rd_index_i), .rd_data_o(rd_data_o), .occupancy_o(occupancy_o),
        .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // The buffer is modelled as the history of distinct accepted addresses
    // since the last flush: the newest NR of them are live, and history item k
    // occupies slot k mod NR.
    typedef enum int {P_IDLE, P_CHECK, P_ALERT, P_FLUSH} phase_t;
    phase_t        phase   = P_IDLE;
    logic [AW-1:0] hist[$];
    logic [AW-1:0] m_chk   = '0;
    logic [AW-1:0] m_fault = '0;
    logic          m_hit   = 1'b0;
    logic [0:0]    exp_q[$];

    function automatic bit in_buf(input logic [AW-1:0] a);
        int n  = hist.size();
        int lo = (n > NR) ? n - NR : 0;
        for (int k = lo; k < n; k++) if (hist[k] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_occ();
        return (hist.size() > NR) ? NR : hist.size();
    endfunction

    function automatic logic [31:0] m_rd(input logic [19:0] idx);
        int s = int'(idx);
        int n = hist.size();
        int k;
        logic [AW-1:0] v;
        if (s >= NR || s >= n) return 32'h0;
        k = s + NR * ((n - 1 - s) / NR);
        v = hist[k];
        return v[31:0];
    endfunction

    function automatic guard_state_e m_state();
        case (phase)
            P_CHECK: return CHECK;
            P_ALERT: return ALERT;
            P_FLUSH: return FLUSH;
            default: return IDLE;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                phase   = P_IDLE;
                hist.delete();
                exp_q.delete();
                m_fault = '0;
            end else begin
                case (phase)
                    P_IDLE: begin
                        if (flush_i) phase = P_FLUSH;
                        else if (chk_valid_i) begin
                            m_chk = chk_addr_i;
                            m_hit = in_buf(chk_addr_i);
                            exp_q.push_back(m_hit);
                            phase = P_CHECK;
                        end else if (rec_valid_i) begin
                            if (!in_buf(rec_addr_i)) hist.push_back(rec_addr_i);
                        end
                    end
                    P_CHECK: begin
                        if (m_hit && !debug_mode_i) begin
                            m_fault = m_chk;
                            phase   = P_ALERT;
                        end else phase = P_IDLE;
                    end
                    P_ALERT: if (crash_ack_i) phase = P_FLUSH;
                    default: begin
                        hist.delete();
                        phase = P_IDLE;
                    end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1) begin
                cmp("rec_ready", 64'(rec_ready_o), 64'(phase == P_IDLE && !flush_i && !chk_valid_i));
                cmp("chk_ready", 64'(chk_ready_o), 64'(phase == P_IDLE && !flush_i));
                cmp("chk_done", 64'(chk_done_o), 64'(phase == P_CHECK));
                cmp("crash", 64'(crash_o), 64'(phase == P_ALERT));
                cmp("fault_addr", fault_addr_o, m_fault);
                cmp("occupancy", 64'(occupancy_o), 64'(m_occ()));
                cmp("rd_data", 64'(rd_data_o), 64'(m_rd(rd_index_i)));
                cmp("state", 64'(state_o), 64'(m_state()));
                if (chk_done_o === 1'b1) begin
                    cmp("chk_pending", 64'(exp_q.size()), 64'(1));
                    if (exp_q.size() > 0) cmp("chk_hit", 64'(chk_hit_o), 64'(exp_q.pop_front()));
                end else begin
                    cmp("chk_hit_quiet", 64'(chk_hit_o), 64'(0));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    task automatic do_record(input logic [AW-1:0] a);
        bit acc = 1'b0;
        rec_valid_i = 1'b1;
        rec_addr_i  = a;
        for (int i = 0; i < 20 && !acc; i++) begin
            at_neg();
            acc = rec_ready_o;
            step();
        end
        rec_valid_i = 1'b0;
        cmp("rec_accept", 64'(acc), 64'(1));
    endtask

    task automatic do_check(input logic [AW-1:0] a);
        bit acc = 1'b0;
        chk_valid_i = 1'b1;
        chk_addr_i  = a;
        for (int i = 0; i < 20 && !acc; i++) begin
            at_neg();
            acc = chk_ready_o;
            step();
        end
        chk_valid_i = 1'b0;
        cmp("chk_accept", 64'(acc), 64'(1));
    endtask

    function automatic logic [AW-1:0] addr_a(input int i);
        return 64'h0000_0040_0000_2000 + 64'(i) * 64'h100;
    endfunction

    // ---------------- directed sequences ----------------
    initial begin
        logic [AW-1:0] a6;
        logic [AW-1:0] a5;
        rst_ni = 1'b0; debug_mode_i = 1'b0; rec_valid_i = 1'b0; rec_addr_i = '0;
        chk_valid_i = 1'b0; chk_addr_i = '0; flush_i = 1'b0; crash_ack_i = 1'b0;
        rd_index_i = '0;

        // reset values
        repeat (3) @(posedge clk_i);
        at_neg();
        cmp("rst_crash", 64'(crash_o), 64'(0));
        cmp("rst_done", 64'(chk_done_o), 64'(0));
        cmp("rst_hit", 64'(chk_hit_o), 64'(0));
        cmp("rst_occ", 64'(occupancy_o), 64'(0));
        cmp("rst_fault", fault_addr_o, 64'(0));
        cmp("rst_state", 64'(state_o), 64'(IDLE));
        step();
        rst_ni = 1'b1;
        at_neg();
        cmp("rel_rec_ready", 64'(rec_ready_o), 64'(1));
        cmp("rel_chk_ready", 64'(chk_ready_o), 64'(1));
        step();

        // record then hit: alarm until ack, then flush
        do_record(64'h8000_1000);
        do_check(64'h8000_1000);
        at_neg();
        cmp("hit_done", 64'(chk_done_o), 64'(1));
        cmp("hit_flag", 64'(chk_hit_o), 64'(1));
        step(); at_neg();
        cmp("alert_crash", 64'(crash_o), 64'(1));
        cmp("alert_fault", fault_addr_o, 64'h8000_1000);
        step(); step(); at_neg();
        cmp("alert_hold", 64'(crash_o), 64'(1));
        step(); crash_ack_i = 1'b1;
        step(); crash_ack_i = 1'b0;
        at_neg();
        cmp("flush_state", 64'(state_o), 64'(FLUSH));
        step(); at_neg();
        cmp("flush_occ", 64'(occupancy_o), 64'(0));
        cmp("flush_idle", 64'(state_o), 64'(IDLE));
        step();

        // duplicate record and debug read
        do_record(64'h10);
        do_record(64'h10);
        rd_index_i = 20'd1;
        at_neg();
        cmp("dup_occ", 64'(occupancy_o), 64'(1));
        cmp("rd_empty_slot", 64'(rd_data_o), 64'(0));
        step(); rd_index_i = 20'd0;
        at_neg();
        cmp("rd_slot0", 64'(rd_data_o), 64'h10);
        step(); flush_i = 1'b1;
        at_neg();
        cmp("flush_blocks_rec", 64'(rec_ready_o), 64'(0));
        step(); flush_i = 1'b0;
        step(); at_neg();
        cmp("flush_in_occ", 64'(occupancy_o), 64'(0));
        step();

        // wrap-around: seven distinct records into six slots
        for (int i = 0; i < 7; i++) do_record(addr_a(i));
        a6 = addr_a(6);
        a5 = addr_a(5);
        at_neg();
        cmp("wrap_occ", 64'(occupancy_o), 64'(6));
        step(); rd_index_i = 20'd0;
        at_neg();
        cmp("wrap_rd0", 64'(rd_data_o), 64'(a6[31:0]));
        step(); rd_index_i = 20'd5;
        at_neg();
        cmp("wrap_rd5", 64'(rd_data_o), 64'(a5[31:0]));
        step(); rd_index_i = 20'd6;
        at_neg();
        cmp("rd_out_of_range", 64'(rd_data_o), 64'(0));
        step(); rd_index_i = 20'hFFFFF;
        at_neg();
        cmp("rd_max_index", 64'(rd_data_o), 64'(0));
        step(); rd_index_i = 20'd0;
        do_check(addr_a(0));
        at_neg();
        cmp("evicted_miss", 64'(chk_hit_o), 64'(0));
        step();
        do_check(addr_a(1) ^ 64'h8000_0000_0000_0000);
        at_neg();
        cmp("msb_miss", 64'(chk_hit_o), 64'(0));
        step();
        do_check(a6);
        at_neg();
        cmp("newest_hit", 64'(chk_hit_o), 64'(1));
        step(); at_neg();
        cmp("newest_fault", fault_addr_o, a6);
        step(); crash_ack_i = 1'b1;
        step(); crash_ack_i = 1'b0;
        step();

        // acknowledge outside ALERT has no effect
        crash_ack_i = 1'b1;
        at_neg();
        cmp("stray_ack_state", 64'(state_o), 64'(IDLE));
        step(); crash_ack_i = 1'b0;

        // check beats a simultaneous record; record lands two cycles later
        do_record(64'h500);
        chk_valid_i = 1'b1; chk_addr_i = 64'h600;
        rec_valid_i = 1'b1; rec_addr_i = 64'h700;
        at_neg();
        cmp("prio_chk_ready", 64'(chk_ready_o), 64'(1));
        cmp("prio_rec_ready", 64'(rec_ready_o), 64'(0));
        step(); chk_valid_i = 1'b0;
        at_neg();
        cmp("prio_in_check", 64'(rec_ready_o), 64'(0));
        step(); at_neg();
        cmp("prio_rec_late", 64'(rec_ready_o), 64'(1));
        step(); rec_valid_i = 1'b0;
        at_neg();
        cmp("prio_occ", 64'(occupancy_o), 64'(2));
        step();

        // flush beats check
        flush_i = 1'b1; chk_valid_i = 1'b1; chk_addr_i = 64'h500;
        at_neg();
        cmp("flush_beats_chk", 64'(chk_ready_o), 64'(0));
        step(); flush_i = 1'b0; chk_valid_i = 1'b0;
        step(); at_neg();
        cmp("flush2_occ", 64'(occupancy_o), 64'(0));
        step();

        // debug mode: hit reported, no alarm
        debug_mode_i = 1'b1;
        do_record(64'hABC0);
        do_check(64'hABC0);
        at_neg();
        cmp("dbg_hit", 64'(chk_hit_o), 64'(1));
        step(); at_neg();
        cmp("dbg_no_crash", 64'(crash_o), 64'(0));
        cmp("dbg_idle", 64'(state_o), 64'(IDLE));
        step(); debug_mode_i = 1'b0;

        // reset during ALERT
        do_check(64'hABC0);
        step(); at_neg();
        cmp("pre_rst_crash", 64'(crash_o), 64'(1));
        #2 rst_ni = 1'b0;
        #1;
        cmp("rst_alert_crash", 64'(crash_o), 64'(0));
        cmp("rst_alert_occ", 64'(occupancy_o), 64'(0));
        step(); step(); rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            cmp("rst_alert_no_done", 64'(chk_done_o), 64'(0));
            step();
        end

        // reset during CHECK
        do_record(64'h1234);
        do_check(64'h1234);
        rst_ni = 1'b0;
        #1;
        cmp("rst_check_done", 64'(chk_done_o), 64'(0));
        step(); rst_ni = 1'b1;
        at_neg();
        cmp("rst_check_no_done", 64'(chk_done_o), 64'(0));
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: sequence did not finish by %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
